pll_freq_gen: RTL and testbench
===============================

// Module: pll_freq_gen
// PURPOSE
//  Behavioural frequency synthesiser for the PLL simulation model.
//  - Derives an output clock of period ref_period*D*O/M from the reference clock.
//  - Phase-aligns the output to a reference rising edge once the measured period is stable.
//  - Reports the output period in ps (ns*1000) for downstream phase/duty logic.
//  - Simulation-only block (timescale 1ns/1ps); delay-based output timing is required.
// PARAMETERS
//  M  default 1  feedback multiplier, real-valued, >0
//  D  default 1  input divider, integer >=1
//  O  default 1  output divider, real-valued, >0
// PORTS
//  clk                     in   1   reference clock; all control sampled on its rising edge
//  RST                     in   1   reset, synchronous, active-high
//  PWRDWN                  in   1   power-down; output held low while 1
//  ref_period              in   32  measured reference period, integer ns
//  period_stable           in   1   1 = ref_period valid and stable
//  out                     out  1   synthesised clock
//  out_period_length_1000  out  32  output period in ps, truncated integer
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (RST).
//  - Reset: on a clk rising edge with RST=1, out=0 and out_period_length_1000=0.
//    Any pending toggle is cancelled; the generator is disarmed.
//  - Period: out_period_length_1000 = floor(ref_period*1000*D*O/M).
//    Computed in real arithmetic, then truncated to 32 bits.
//    Updated on every clk rising edge where RST=0 and period_stable=1.
//  - Disarmed state, entered on RST, PWRDWN=1, or period_stable=0:
//    out is driven 0 and no toggles are scheduled.
//  - Arming: the first clk rising edge with RST=0, PWRDWN=0 and period_stable=1 does two things:
//    * drives out=1 at that same edge (zero latency);
//    * starts free-running generation.
//  - Generation:
//    * out stays high for P/2 and low for P/2, where P = out_period_length_1000/1000.0 ns, real delay;
//    * 50% duty; free-running between arming events, with no per-edge re-alignment to clk.
//  - Re-arm: dropping period_stable (or PWRDWN=1) disarms.
//    The next qualifying edge re-arms with the then-current ref_period.
//  - A ref_period change while armed takes effect at the next out rising edge.
//  - ref_period=0 while period_stable=1: treat as disarmed; out=0.
//  - RST has priority over PWRDWN, and PWRDWN over period_stable.
//  - Counter sub-module edge_high_counter, ports clk, rst, count[31:0]:
//    * count increments by 1 on each rising edge of its clk;
//    * synchronous active-high rst sets count=0;
//    * wraps at 2^32-1 -> 0.
//    Instantiated inside pll_freq_gen only for the optional debug output; benches also use it standalone.
// STRUCTURE
//  - Shared package pll_sim_pkg:
//    * PERIOD_SCALE=1000 (ns->ps);
//    * 32-bit period typedef;
//    * real-to-int truncation function.
//  - One sub-module: edge_high_counter (rising-edge counter with sync reset).
//  - Top: control flop logic on clk, plus a behavioural toggle process using # delays derived from P.
// TESTING
//  Each scenario gives stimulus -> required response.
//  1. Reset check.
//     Stimulus: M=D=O=1, ref_period=20 (clk 20ns), RST=1 for one clk edge.
//     Response: out===0 and out_period_length_1000===0 afterwards.
//  2. Arming.
//     Stimulus: set RST=0 and period_stable=1 at t=20; clk rises at t=30.
//     Response: out===1 at t=51.
//  3. Frequency at ref_period=20.
//     Stimulus: edge_high_counter on out, rst=~period_stable, over 1000ns.
//     Response: floor(1000/count)==20.
//  4. Frequency at ref_period=10.
//     Stimulus: drop period_stable, set ref_period=10, wait 1000ns, raise period_stable, wait 1000ns.
//     Response: floor(1010/count)==10, and floor(out_period_length_1000/1000)==10.
//  5. Ratios.
//     Stimulus: M=2, D=1, O=1 at ref_period=20.
//     Response: out_period_length_1000==10000, 10ns out period.
//     Stimulus: M=1, D=2, O=2.
//     Response: 80000 ps.
//  6. Power-down.
//     Stimulus: PWRDWN=1 while armed.
//     Response: out=0 from the next clk edge; count frozen.
//     Stimulus: release PWRDWN.
//     Response: re-arms on the next clk rising edge.

Source files
------------

// File: rtl/pll_sim_pkg.sv
// Shared definitions for the PLL simulation model: period scaling, the
// 32-bit period type and a real-to-integer truncation helper.
`timescale 1ns/1ps
package pll_sim_pkg;

  // ns -> ps scale factor applied to every reported period
  localparam int PERIOD_SCALE = 1000;

  // Width used for every period value moving between blocks
  typedef logic [31:0] period_t;

  // Truncate a real toward zero and keep the low 32 bits. Negative values
  // collapse to zero. Values too large for a longint saturate to all-ones.
  function automatic period_t real_to_period(input real value);
    longint whole;
    if (value <= 0.0) begin
      return '0;
    end
    if (value >= 9.0e18) begin
      return '1;
    end
    whole = longint'($floor(value));
    return period_t'(whole);
  endfunction

endpackage

// File: rtl/pll_freq_gen_counter.sv
// Rising-edge counter with synchronous active-high reset. It wraps from
// 2^32-1 back to 0.
`timescale 1ns/1ps
module edge_high_counter
  import pll_sim_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  output period_t count
);

  // Count every rising edge of clk. A reset seen on an edge clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/pll_freq_gen.sv
// Behavioural frequency synthesiser. It produces a 50% duty clock with
// period ref_period*D*O/M. The clock is phase-aligned to the clk edge that
// arms it and then runs free on real-valued delays.
`timescale 1ns/1ps
module pll_freq_gen
  import pll_sim_pkg::*;
#(
  parameter real M = 1.0,
  parameter int  D = 1,
  parameter real O = 1.0
)(
  input  logic        clk,
  input  logic        RST,
  input  logic        PWRDWN,
  input  logic [31:0] ref_period,
  input  logic        period_stable,
  output logic        out,
  output logic [31:0] out_period_length_1000
);

  logic    armed;
  logic    qualify;
  period_t arm_seq;
  logic    gen_out;
  period_t unused_debug_edges;

  // Output period in ps for a given reference period in ns
  function automatic period_t calc_period(input logic [31:0] rp);
    return real_to_period(real'(rp) * real'(PERIOD_SCALE) * real'(D) * O / M);
  endfunction

  // Generation is only allowed while powered, stable and given a real period
  assign qualify = !PWRDWN && period_stable && (ref_period != '0);

  // Control flops. arm_seq changes on every arm/disarm transition and is odd
  // exactly while the generator is armed. Any toggle scheduled under an older
  // value of arm_seq is dropped when it wakes up.
  always_ff @(posedge clk) begin
    if (RST) begin
      armed                  <= 1'b0;
      arm_seq                <= '0;
      out_period_length_1000 <= '0;
    end else begin
      if (period_stable) begin
        out_period_length_1000 <= calc_period(ref_period);
      end
      armed <= qualify;
      if (qualify != armed) begin
        arm_seq <= arm_seq + 32'd1;
      end
    end
  end

  // Free-running toggle loop for one arming. The first half period comes
  // straight from ref_period because the period register changes on the same
  // edge. Each later rising edge picks up the period register, so a changed
  // ref_period takes effect there. The loop exits as soon as it is stale.
  task automatic run_gen(input period_t seq);
    real half;
    half = real'(calc_period(ref_period)) / real'(PERIOD_SCALE) / 2.0;
    if (half < 0.001) half = 0.001;
    gen_out = 1'b1;
    forever begin
      #(half);
      if (seq != arm_seq) return;
      gen_out = 1'b0;
      #(half);
      if (seq != arm_seq) return;
      half = real'(out_period_length_1000) / real'(PERIOD_SCALE) / 2.0;
      if (half < 0.001) half = 0.001;
      gen_out = 1'b1;
    end
  endtask

  // Launch a fresh generator on every arming edge. Stale generators retire
  // by themselves, so nothing has to be killed here.
  always begin : toggle_launch
    @(arm_seq);
    if (arm_seq[0]) begin
      fork
        run_gen(arm_seq);
      join_none
    end
  end

  // Gating with armed forces out low the moment the generator is disarmed
  assign out = armed & gen_out;

  // Debug count of synthesised rising edges, cleared by reset
  edge_high_counter u_debug_counter (
    .clk   (out),
    .rst   (RST),
    .count (unused_debug_edges)
  );

endmodule

// File: tb/tb_pll_freq_gen.sv
// Directed bench for pll_freq_gen: reset, zero-latency arming, output
// frequency at two reference periods, M/D/O ratios, power-down, zero
// reference period and reset priority.
`timescale 1ns/1ps
module tb_pll_freq_gen;
  import pll_sim_pkg::*;

  logic        clk;
  logic        RST;
  logic        PWRDWN;
  logic [31:0] ref_period;
  logic        period_stable;
  logic        out_main, out_m2, out_do;
  logic [31:0] per_main, per_m2, per_do;
  logic        cnt_rst;
  period_t     cnt_main, cnt_m2;
  int          total;
  int          bad;
  longint      snap_main, snap_m2, diff;

  // Unity ratio instance
  pll_freq_gen #(.M(1.0), .D(1), .O(1.0)) dut (
    .clk(clk), .RST(RST), .PWRDWN(PWRDWN), .ref_period(ref_period),
    .period_stable(period_stable), .out(out_main), .out_period_length_1000(per_main)
  );

  // Doubled frequency instance
  pll_freq_gen #(.M(2.0), .D(1), .O(1.0)) dut_m2 (
    .clk(clk), .RST(RST), .PWRDWN(PWRDWN), .ref_period(ref_period),
    .period_stable(period_stable), .out(out_m2), .out_period_length_1000(per_m2)
  );

  // Divide-by-four instance
  pll_freq_gen #(.M(1.0), .D(2), .O(2.0)) dut_do (
    .clk(clk), .RST(RST), .PWRDWN(PWRDWN), .ref_period(ref_period),
    .period_stable(period_stable), .out(out_do), .out_period_length_1000(per_do)
  );

  // Standalone edge counters watching the synthesised clocks
  assign cnt_rst = ~period_stable;
  edge_high_counter u_cnt_main (.clk(out_main), .rst(cnt_rst), .count(cnt_main));
  edge_high_counter u_cnt_m2   (.clk(out_m2),   .rst(cnt_rst), .count(cnt_m2));

  // 20 ns reference clock with rising edges at 10, 30, 50, ...
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Drive every control input at once
  task automatic applyStimulus(input logic rst, input logic pwrdwn,
                               input logic stable, input logic [31:0] rp);
    RST           = rst;
    PWRDWN        = pwrdwn;
    period_stable = stable;
    ref_period    = rp;
  endtask

  // Compare one observed value against its expected value and log a mismatch
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance to an absolute simulation time in ns
  task automatic waitUntil(input longint t);
    #(t - longint'($time));
  endtask

  // Directed scenario timeline. All samples are taken 1 ns or more away from clk edges.
  initial begin
    total = 0;
    bad   = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd20);

    waitUntil(15);
    checkOutput("reset_out", out_main, 0);
    checkOutput("reset_period", per_main, 0);
    checkOutput("reset_period_m2", per_m2, 0);

    waitUntil(20);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd20);

    waitUntil(31);
    checkOutput("arm_out_same_edge", out_main, 1);
    checkOutput("period_20", per_main, 20000);
    checkOutput("ratio_m2_period", per_m2, 10000);
    checkOutput("ratio_do_period", per_do, 80000);
    checkOutput("ratio_do_out_high", out_do, 1);
    snap_main = longint'(cnt_main);
    snap_m2   = longint'(cnt_m2);

    waitUntil(36);
    checkOutput("m2_low_half", out_m2, 0);
    waitUntil(41);
    checkOutput("main_low_half", out_main, 0);
    checkOutput("m2_second_high", out_m2, 1);
    waitUntil(51);
    checkOutput("arm_out_t51", out_main, 1);
    checkOutput("do_still_high", out_do, 1);
    waitUntil(71);
    checkOutput("do_low_half", out_do, 0);

    waitUntil(1031);
    diff = longint'(cnt_main) - snap_main;
    checkOutput("edges_ref20", diff, 50);
    checkOutput("freq_ref20", (diff > 0) ? 1000 / diff : -1, 20);
    checkOutput("edges_m2", longint'(cnt_m2) - snap_m2, 100);
    checkOutput("period_20_held", per_main, 20000);

    waitUntil(1040);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd10);
    waitUntil(1051);
    checkOutput("disarm_out", out_main, 0);
    checkOutput("unstable_period_held", per_main, 20000);

    waitUntil(2040);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd10);
    waitUntil(2041);
    snap_main = longint'(cnt_main);
    waitUntil(2051);
    checkOutput("rearm_out", out_main, 1);
    checkOutput("period_10", per_main, 10000);
    checkOutput("ratio_m2_period_10", per_m2, 5000);
    checkOutput("ratio_do_period_10", per_do, 40000);
    waitUntil(2056);
    checkOutput("ref10_low_half", out_main, 0);

    waitUntil(3051);
    diff = longint'(cnt_main) - snap_main;
    checkOutput("edges_ref10", diff, 101);
    checkOutput("freq_ref10", (diff > 0) ? 1010 / diff : -1, 10);
    checkOutput("period_ns_10", longint'(per_main) / 1000, 10);

    waitUntil(3060);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd10);
    waitUntil(3071);
    checkOutput("pwrdwn_out", out_main, 0);
    checkOutput("pwrdwn_period", per_main, 10000);
    snap_main = longint'(cnt_main);
    waitUntil(3151);
    checkOutput("pwrdwn_count_frozen", longint'(cnt_main), snap_main);
    checkOutput("pwrdwn_out_later", out_main, 0);

    waitUntil(3160);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd10);
    waitUntil(3171);
    checkOutput("pwrup_rearm", out_main, 1);
    waitUntil(3176);
    checkOutput("pwrup_low_half", out_main, 0);
    waitUntil(3181);
    checkOutput("pwrup_second_high", out_main, 1);

    waitUntil(3200);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
    waitUntil(3211);
    checkOutput("zero_ref_out", out_main, 0);
    checkOutput("zero_ref_period", per_main, 0);

    waitUntil(3220);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd20);
    waitUntil(3231);
    checkOutput("rearm_after_zero", out_main, 1);
    checkOutput("period_after_zero", per_main, 20000);

    waitUntil(3240);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd20);
    waitUntil(3251);
    checkOutput("rst_prio_out", out_main, 0);
    checkOutput("rst_prio_period", per_main, 0);
    checkOutput("rst_prio_out_m2", out_m2, 0);

    waitUntil(3260);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd20);
    waitUntil(3271);
    checkOutput("arm_after_reset", out_main, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
